// File: rtl/inst_cache_pkg.sv
// Shared types and width derivation for the direct-mapped instruction cache.
// Widths are computed from LINES and WORDS_PER_LINE, so the modules stay parameter-generic.
package inst_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Byte offset within a line: word select bits plus the two ignored byte bits.
    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words_per_line);
        return 32 - offset_w(words_per_line) - index_w(lines);
    endfunction

    function automatic int beat_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/inst_cache_line_store.sv
// Valid/tag/data arrays of the instruction cache, all in flops.
// Only the valid bits are reset; tags and data are qualified by them.
module inst_cache_line_store
    import inst_cache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W  = index_w(LINES),
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE),
    localparam int BEAT_W = beat_w(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [BEAT_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic              word_we,
    input  logic [BEAT_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              valid_set,
    input  logic              flush_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    // Flush wins over a same-cycle line completion so a fence.i is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (tag_we && valid_set) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[wr_index][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped blocking instruction cache: combinational hit path, one-line burst refill on miss.
// Optional ICACHE_PERF_CNT_EN adds free-running hit_cnt / miss_cnt outputs.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        inst_cache_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W  = offset_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
    localparam int BEAT_W = beat_w(WORDS_PER_LINE);

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic              flush_pending;

    logic [IDX_W-1:0]  pc_index;
    logic [BEAT_W-1:0] pc_word;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic              pc_unused;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;

    logic              hit;
    logic              beat_fire;
    logic              last_beat;
    logic              flush_now;
    logic              flush_all;

    assign pc_index   = pc[OFF_W +: IDX_W];
    assign pc_word    = pc[2 +: BEAT_W];
    assign pc_tag     = pc[31 -: TAG_W];
    assign pc_unused  = ^pc[1:0];

    // The refill only ever uses the latched line address, never the live pc.
    assign fill_index = mem_addr[OFF_W +: IDX_W];
    assign fill_tag   = mem_addr[31 -: TAG_W];

    assign hit        = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign beat_fire  = (state == REFILL) && mem_rvalid;
    assign last_beat  = beat_fire && (beat_cnt == BEAT_W'(WORDS_PER_LINE - 1));
    assign flush_now  = flush || flush_pending;
    assign flush_all  = ((state == IDLE) && flush) || (last_beat && flush_now);

    assign inst_cache_ready = hit;
    assign inst             = rd_data;

    inst_cache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc_index),
        .rd_word   (pc_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (fill_index),
        .word_we   (beat_fire),
        .wr_word   (beat_cnt),
        .wr_data   (mem_rdata),
        .tag_we    (last_beat),
        .wr_tag    (fill_tag),
        .valid_set (!flush_now),
        .flush_all (flush_all)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        state    <= REFILL;
                        mem_req  <= 1'b1;
                        mem_addr <= {pc_tag, pc_index, {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                    // Completion overrides the increment and any pending-flush set above.
                    if (last_beat) begin
                        state         <= IDLE;
                        mem_req       <= 1'b0;
                        beat_cnt      <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if ((state == IDLE) && !hit) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: vector table of fetches plus hand-written flush/reset sequences.
// A negedge-driven memory model serves refill bursts; expected instructions go through a queue.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        inst_cache_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    inst_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .flush            (flush),
        .inst             (inst),
        .inst_cache_ready (inst_cache_ready),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];

    // Memory model state
    bit gap_en    = 1'b0;
    bit gap_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int gap_i     = 0;
    int drv_beat  = 0;
    bit drv_v;
    bit flush_arm = 1'b0;
    bit flush_drv = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:2], 2'b11};
    endfunction

    always @(negedge clk) begin
        if (!mem_req) begin
            drv_beat   = 0;
            gap_i      = 0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end else begin
            drv_v = gap_en ? ((gap_i < 7) ? gap_pat[gap_i] : 1'b1) : 1'b1;
            gap_i++;
            mem_rvalid = drv_v;
            mem_rdata  = drv_v ? mem_word(mem_addr + 32'(drv_beat * 4)) : 32'hDEAD_BEEF;
            if (flush_arm && drv_v && drv_beat == 1) begin
                flush     = 1'b1;
                flush_arm = 1'b0;
                flush_drv = 1'b1;
            end else if (flush_drv) begin
                flush     = 1'b0;
                flush_drv = 1'b0;
            end
            if (drv_v) drv_beat++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive pc, count stall cycles until a hit, check refill address and returned word.
    task automatic fetch(input logic [31:0] a, input int exp_low, input logic [31:0] exp_maddr,
                         input string name);
        int low       = 0;
        bit addr_seen = 1'b0;
        bit done      = 1'b0;
        pc = a;
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (inst_cache_ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (mem_req && !addr_seen) begin
                    addr_seen = 1'b1;
                    check({name, " mem_addr"}, mem_addr, exp_maddr);
                end
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s timeout: ready still low after 60 cycles", name);
            void'(exp_q.pop_front());
        end else begin
            check({name, " req_seen"}, 32'(addr_seen), 32'(exp_low > 0));
            check({name, " low_cycles"}, 32'(low), 32'(exp_low));
            check({name, " inst"}, inst, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        int          low;
        logic [31:0] maddr;
        bit          gapped;
        string       name;
    } vec_t;

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{32'h0000_0100, 5, 32'h0000_0100, 1'b0, "cold_100"};
        vt[1]  = '{32'h0000_0104, 0, 32'h0,         1'b0, "hit_104"};
        vt[2]  = '{32'h0000_0108, 0, 32'h0,         1'b0, "hit_108"};
        vt[3]  = '{32'h0000_010C, 0, 32'h0,         1'b0, "hit_10c"};
        vt[4]  = '{32'h0000_0000, 5, 32'h0000_0000, 1'b0, "conflict_000"};
        vt[5]  = '{32'h0000_0100, 5, 32'h0000_0100, 1'b0, "conflict_100"};
        vt[6]  = '{32'h0000_0004, 5, 32'h0000_0000, 1'b0, "conflict_004"};
        vt[7]  = '{32'h0000_02A8, 8, 32'h0000_02A0, 1'b1, "gapped_2a8"};
        vt[8]  = '{32'h0000_02A0, 0, 32'h0,         1'b0, "gapped_w0"};
        vt[9]  = '{32'h0000_02A4, 0, 32'h0,         1'b0, "gapped_w1"};
        vt[10] = '{32'h0000_02AC, 0, 32'h0,         1'b0, "gapped_w3"};
        vt[11] = '{32'h0000_0008, 0, 32'h0,         1'b0, "hit_008"};

        rst        = 1'b1;
        pc         = 32'h0000_0100;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset ready", 32'(inst_cache_ready), 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        check("reset hit_cnt", hit_cnt, 32'h0);
        check("reset miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            gap_en = vt[i].gapped;
            fetch(vt[i].pc, vt[i].low, vt[i].maddr, vt[i].name);
`ifdef ICACHE_PERF_CNT_EN
            if (i == 3) begin
                check("perf hit_cnt", hit_cnt, 32'd4);
                check("perf miss_cnt", miss_cnt, 32'd1);
            end
`endif
        end
        gap_en = 1'b0;

        // Flush on the second beat: line completes but stays invalid, so it refills again.
        flush_arm = 1'b1;
        fetch(32'h0000_01C0, 10, 32'h0000_01C0, "flush_refill");
        fetch(32'h0000_01C4, 0, 32'h0, "after_flush_refill");

        // Flush in IDLE: same-cycle lookup still hits, afterwards everything misses.
        fetch(32'h0000_0100, 5, 32'h0000_0100, "pre_flush_100");
        fetch(32'h0000_0140, 5, 32'h0000_0140, "pre_flush_140");
        pc    = 32'h0000_0104;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle ready", 32'(inst_cache_ready), 32'h1);
        check("flush_cycle inst", inst, mem_word(32'h0000_0104));
        @(posedge clk);
        #1;
        flush = 1'b0;
        fetch(32'h0000_0108, 5, 32'h0000_0100, "post_flush_108");
        fetch(32'h0000_014C, 5, 32'h0000_0140, "post_flush_14c");

        // Reset after two beats: mem_req must drop without a clock edge.
        pc = 32'h0000_0300;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid mem_req", 32'(mem_req), 32'h0);
        check("rst_mid ready", 32'(inst_cache_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        fetch(32'h0000_0300, 5, 32'h0000_0300, "rst_refill_300");
        fetch(32'h0000_030C, 0, 32'h0, "rst_refill_30c");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
